// File: rtl/ntp_key_fetch_if.sv
// Lookup, response and keymem handshake signals of the NTP key fetcher.
// slave is the fetcher's view; master is the surrounding pipeline/keymem view.
interface ntp_key_fetch_if;
  logic         lookup_valid;
  logic [31:0]  lookup_id;
  logic         lookup_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_key;
  logic         rsp_error;
  logic         rsp_cached;
  logic         key_req;
  logic [31:0]  key_id;
  logic         key_ack;
  logic [255:0] key;

  modport master (
    output lookup_valid, lookup_id, rsp_ready, key_ack, key,
    input  lookup_ready, rsp_valid, rsp_key, rsp_error, rsp_cached, key_req, key_id
  );

  modport slave (
    input  lookup_valid, lookup_id, rsp_ready, key_ack, key,
    output lookup_ready, rsp_valid, rsp_key, rsp_error, rsp_cached, key_req, key_id
  );
endinterface

// File: rtl/ntp_key_fetch.sv
// Keymem requester: fetch a 256-bit key by ID, timeout -> error response; optional one-entry cache (NTP_KEY_FETCH_CACHE_EN).
// Latency: key_req one cycle after lookup accept, response one cycle after key_ack (cache hit: one cycle after accept).
// Backpressure: one lookup outstanding; response held stable until rsp_ready, lookup_ready low meanwhile.
module ntp_key_fetch #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter int          CNT_WIDTH      = 32
) (
  input  logic                 key_clk,
  input  logic                 key_aresetn,
  ntp_key_fetch_if.slave       kif,
  input  logic                 cache_flush,
  output logic [CNT_WIDTH-1:0] cnt_fetch,
  output logic [CNT_WIDTH-1:0] cnt_timeout,
  output logic [CNT_WIDTH-1:0] cnt_spurious
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RSP} state_t;

  localparam logic [15:0]          TMO_LAST = TIMEOUT_CYCLES - 16'd1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [15:0]  tcnt;
  logic [31:0]  key_id_q;
  logic [255:0] rsp_key_q;
  logic         rsp_error_q;
  logic         rsp_cached_q;
  logic         cache_hit;
  logic [255:0] cache_key;
  logic         ack_take;
  logic         tmo_hit;
  logic         hit_take;
  logic         rsp_done;
  logic         spurious;

  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_take  = 1'b0;
    tmo_hit   = 1'b0;
    hit_take  = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (kif.lookup_valid) begin
          if (cache_hit) begin
            hit_take  = 1'b1;
            state_nxt = S_RSP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // An ack on the terminal count still delivers the key.
        if (kif.key_ack) begin
          ack_take  = 1'b1;
          state_nxt = S_RSP;
        end else if (tcnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (kif.rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign spurious = kif.key_ack && (state != S_WAIT);

  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      tcnt         <= '0;
      key_id_q     <= '0;
      rsp_key_q    <= '0;
      rsp_error_q  <= 1'b0;
      rsp_cached_q <= 1'b0;
    end else begin
      if (state == S_IDLE) tcnt <= '0;
      else if (state == S_WAIT) tcnt <= tcnt + 16'd1;

      if ((state == S_IDLE) && kif.lookup_valid) key_id_q <= kif.lookup_id;

      if (ack_take) begin
        rsp_key_q    <= kif.key;
        rsp_error_q  <= 1'b0;
        rsp_cached_q <= 1'b0;
      end else if (tmo_hit) begin
        rsp_key_q    <= '0;
        rsp_error_q  <= 1'b1;
        rsp_cached_q <= 1'b0;
      end else if (hit_take) begin
        rsp_key_q    <= cache_key;
        rsp_error_q  <= 1'b0;
        rsp_cached_q <= 1'b1;
      end else if (rsp_done) begin
        // Do not leave key material sitting on the response bus.
        rsp_key_q    <= '0;
        rsp_error_q  <= 1'b0;
        rsp_cached_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      cnt_fetch    <= '0;
      cnt_timeout  <= '0;
      cnt_spurious <= '0;
    end else begin
      if (ack_take && (cnt_fetch != '1))   cnt_fetch    <= cnt_fetch + CNT_ONE;
      if (tmo_hit && (cnt_timeout != '1))  cnt_timeout  <= cnt_timeout + CNT_ONE;
      if (spurious && (cnt_spurious != '1)) cnt_spurious <= cnt_spurious + CNT_ONE;
    end
  end

`ifdef NTP_KEY_FETCH_CACHE_EN
  logic         cache_vld;
  logic [31:0]  cache_id;
  logic [255:0] cache_key_q;

  // A flush in the same cycle as a fetch write leaves the entry invalid.
  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      cache_vld   <= 1'b0;
      cache_id    <= '0;
      cache_key_q <= '0;
    end else if (cache_flush) begin
      cache_vld <= 1'b0;
    end else if (ack_take) begin
      cache_vld   <= 1'b1;
      cache_id    <= key_id_q;
      cache_key_q <= kif.key;
    end
  end

  assign cache_hit = cache_vld && (cache_id == kif.lookup_id);
  assign cache_key = cache_key_q;
`else
  logic unused_cache_flush;
  assign unused_cache_flush = cache_flush;
  assign cache_hit          = 1'b0;
  assign cache_key          = '0;
`endif

  assign kif.lookup_ready = (state == S_IDLE);
  assign kif.key_req      = (state == S_WAIT);
  assign kif.key_id       = key_id_q;
  assign kif.rsp_valid    = (state == S_RSP);
  assign kif.rsp_key      = rsp_key_q;
  assign kif.rsp_error    = rsp_error_q;
  assign kif.rsp_cached   = rsp_cached_q;

endmodule

// File: tb/tb_ntp_key_fetch.sv
// Directed bench for ntp_key_fetch: fetch, timeout, terminal-count ack, backpressure, reset, saturation, cache.
module tb_ntp_key_fetch;
  localparam int CW = 3;

  logic          key_clk;
  logic          key_aresetn;
  logic          cache_flush;
  logic [CW-1:0] cnt_fetch, cnt_timeout, cnt_spurious;

  int checks = 0;
  int errors = 0;

  ntp_key_fetch_if kif ();

  ntp_key_fetch #(.TIMEOUT_CYCLES(16'd16), .CNT_WIDTH(CW)) dut (
    .key_clk      (key_clk),
    .key_aresetn  (key_aresetn),
    .kif          (kif.slave),
    .cache_flush  (cache_flush),
    .cnt_fetch    (cnt_fetch),
    .cnt_timeout  (cnt_timeout),
    .cnt_spurious (cnt_spurious)
  );

  initial key_clk = 1'b0;
  always #5 key_clk = ~key_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge key_clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] id);
    kif.lookup_valid = 1'b1;
    kif.lookup_id    = id;
    tick();
    kif.lookup_valid = 1'b0;
  endtask

  // Counts key_req-high cycles; acks in WAIT cycle number ack_at (0 = never).
  task automatic wait_req(input int ack_at, input logic [255:0] kv, input logic fl, output int hi);
    hi = 0;
    for (int n = 0; n < 100 && kif.key_req; n++) begin
      hi++;
      if (hi == ack_at) begin
        kif.key_ack = 1'b1;
        kif.key     = kv;
        cache_flush = fl;
      end
      tick();
      kif.key_ack = 1'b0;
      kif.key     = '1;
      cache_flush = 1'b0;
    end
    if (kif.key_req) chk("req_bound", 1'b1, 1'b0);
  endtask

  task automatic handshake();
    kif.rsp_ready = 1'b1;
    tick();
    kif.rsp_ready = 1'b0;
  endtask

  logic [255:0] key_a5, key_t, key_sp, key_9;
  int hi;
  int seen;

  initial begin
    key_a5 = {32{8'hA5}};
    key_t  = {8{32'h0123_4567}};
    key_sp = {8{32'hFFFF_0000}};
    key_9  = {8{32'h9999_5A5A}};

    key_aresetn      = 1'b0;
    cache_flush      = 1'b0;
    kif.lookup_valid = 1'b0;
    kif.lookup_id    = '0;
    kif.rsp_ready    = 1'b0;
    kif.key_ack      = 1'b0;
    kif.key          = '0;
    #1;
    chk("rst_lookup_ready", kif.lookup_ready, 1'b1);
    chk("rst_key_req", kif.key_req, 1'b0);
    chk("rst_key_id", kif.key_id, 32'h0);
    chk("rst_rsp_valid", kif.rsp_valid, 1'b0);
    chk("rst_rsp_key", kif.rsp_key, 256'h0);
    chk("rst_rsp_error", kif.rsp_error, 1'b0);
    chk("rst_rsp_cached", kif.rsp_cached, 1'b0);
    chk("rst_counters", {cnt_fetch, cnt_timeout, cnt_spurious}, '0);
    tick();
    key_aresetn = 1'b1;
    tick();

    // Basic fetch: ack in the 3rd WAIT cycle
    do_lookup(32'h0000_0007);
    chk("basic_req", kif.key_req, 1'b1);
    chk("basic_key_id", kif.key_id, 32'h7);
    chk("basic_lookup_ready", kif.lookup_ready, 1'b0);
    wait_req(3, key_a5, 1'b0, hi);
    chk("basic_req_len", hi, 3);
    chk("basic_rsp_valid", kif.rsp_valid, 1'b1);
    chk("basic_rsp_key", kif.rsp_key, key_a5);
    chk("basic_rsp_error", kif.rsp_error, 1'b0);
    chk("basic_rsp_cached", kif.rsp_cached, 1'b0);
    chk("basic_cnt_fetch", cnt_fetch, 3'd1);
    handshake();
    chk("basic_done_valid", kif.rsp_valid, 1'b0);
    chk("basic_done_ready", kif.lookup_ready, 1'b1);
    chk("basic_key_hygiene", kif.rsp_key, 256'h0);

    // Timeout: no ack
    do_lookup(32'h0000_0011);
    wait_req(0, key_a5, 1'b0, hi);
    chk("tmo_req_len", hi, 16);
    chk("tmo_rsp_valid", kif.rsp_valid, 1'b1);
    chk("tmo_rsp_error", kif.rsp_error, 1'b1);
    chk("tmo_rsp_key", kif.rsp_key, 256'h0);
    chk("tmo_cnt_timeout", cnt_timeout, 3'd1);
    chk("tmo_cnt_fetch", cnt_fetch, 3'd1);
    handshake();

    // Ack on the terminal count
    do_lookup(32'h0000_0022);
    chk("term_key_id", kif.key_id, 32'h22);
    wait_req(16, key_t, 1'b0, hi);
    chk("term_req_len", hi, 16);
    chk("term_rsp_error", kif.rsp_error, 1'b0);
    chk("term_rsp_key", kif.rsp_key, key_t);
    chk("term_cnt_timeout", cnt_timeout, 3'd1);
    chk("term_cnt_fetch", cnt_fetch, 3'd2);

    // Backpressure with a spurious ack during RSP
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        kif.key_ack = 1'b1;
        kif.key     = key_sp;
      end
      tick();
      kif.key_ack = 1'b0;
      if (!kif.rsp_valid || kif.rsp_key !== key_t || kif.rsp_error || kif.lookup_ready) seen++;
    end
    chk("bp_unstable_cycles", seen, 0);
    chk("bp_rsp_key", kif.rsp_key, key_t);
    chk("bp_lookup_ready", kif.lookup_ready, 1'b0);
    chk("bp_cnt_spurious", cnt_spurious, 3'd1);
    chk("bp_cnt_fetch", cnt_fetch, 3'd2);
    handshake();
    chk("bp_key_hygiene", kif.rsp_key, 256'h0);

    // Reset while waiting on keymem
    do_lookup(32'h0000_0033);
    tick();
    tick();
    chk("rstw_req_before", kif.key_req, 1'b1);
    #2;
    key_aresetn = 1'b0;
    #1;
    chk("rstw_req_async", kif.key_req, 1'b0);
    chk("rstw_lookup_ready", kif.lookup_ready, 1'b1);
    tick();
    tick();
    key_aresetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (kif.rsp_valid || kif.key_req) seen++;
    end
    chk("rstw_no_rsp", seen, 0);
    chk("rstw_counters", {cnt_fetch, cnt_timeout, cnt_spurious}, '0);
    chk("rstw_key_id", kif.key_id, 32'h0);

`ifdef NTP_KEY_FETCH_CACHE_EN
    do_lookup(32'h0000_0009);
    wait_req(2, key_9, 1'b0, hi);
    chk("c_fill_key", kif.rsp_key, key_9);
    handshake();
    do_lookup(32'h0000_0009);
    chk("c_hit_valid", kif.rsp_valid, 1'b1);
    chk("c_hit_cached", kif.rsp_cached, 1'b1);
    chk("c_hit_req", kif.key_req, 1'b0);
    chk("c_hit_key", kif.rsp_key, key_9);
    chk("c_hit_cnt_fetch", cnt_fetch, 3'd1);
    handshake();
    chk("c_hit_cached_clr", kif.rsp_cached, 1'b0);
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    do_lookup(32'h0000_0009);
    chk("c_flush_req", kif.key_req, 1'b1);
    // Refill coincides with a flush: entry must stay invalid
    wait_req(1, key_9, 1'b1, hi);
    chk("c_refill_cached", kif.rsp_cached, 1'b0);
    handshake();
    do_lookup(32'h0000_0009);
    chk("c_flushwin_req", kif.key_req, 1'b1);
    wait_req(0, key_9, 1'b0, hi);
    handshake();
`endif

    // Spurious acks in IDLE, saturating counter
    kif.key_ack = 1'b1;
    tick();
    kif.key_ack = 1'b0;
    chk("sat_spurious_1", cnt_spurious, 3'd1);
    chk("sat_idle_no_capture", kif.rsp_key, 256'h0);
    kif.key_ack = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    kif.key_ack = 1'b0;
    chk("sat_spurious_max", cnt_spurious, 3'd7);
    chk("sat_idle_ready", kif.lookup_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntp_key_fetch.md
Name: ntp_key_fetch

Overview:
- Requester (initiator) end of the keymem key interface (key_req / key_id / key_ack / key), in the key_clk domain of the network path.
- Accepts key lookups by 32-bit key ID from the NTP authentication pipeline and drives the keymem request/ack handshake.
- Returns the 256-bit key, or an error on timeout, through a valid/ready response port.
- Keeps fetch and timeout statistics.

Parameters:
- TIMEOUT_CYCLES, 16'd1000, max key_clk cycles to wait for key_ack after key_req rises; legal range 1..65535.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- key_clk  in  1  block clock (clk156 domain).
- key_aresetn  in  1  reset; asynchronous, active-low.
- lookup_valid  in  1  lookup request valid.
- lookup_id  in  32  key ID to fetch.
- lookup_ready  out  1  block can accept a lookup.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_key  out  256  fetched key; all-zero when rsp_error.
- rsp_error  out  1  fetch timed out.
- rsp_cached  out  1  response served from cache (0 when feature absent).
- key_req  out  1  keymem request, level.
- key_id  out  32  keymem key ID, stable while key_req=1.
- key_ack  in  1  keymem single-cycle acknowledge.
- key  in  256  key data, valid in the key_ack cycle.
- cache_flush  in  1  invalidate cached key (ignored when feature absent).
- cnt_fetch  out  CNT_WIDTH  completed keymem fetches.
- cnt_timeout  out  CNT_WIDTH  timed-out fetches.
- cnt_spurious  out  CNT_WIDTH  key_ack seen while not in WAIT.

Behaviour:
- Reset (async assert, sync release): state=IDLE, lookup_ready=1, key_req=0, key_id=0, rsp_valid=0, rsp_key=0, rsp_error=0, rsp_cached=0, all counters 0, cache invalid.
- FSM states: IDLE, WAIT, RSP.
- IDLE: lookup_ready=1. On lookup_valid:
  - latch lookup_id into key_id;
  - next cycle key_req=1, enter WAIT, clear the timeout counter.
- WAIT: lookup_ready=0, key_req held high, key_id held stable, timeout counter increments each cycle.
  - key_ack=1: capture key into rsp_key, rsp_error=0, cnt_fetch+1, key_req=0 on the next cycle, enter RSP.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: rsp_key=0, rsp_error=1, cnt_timeout+1, key_req=0, enter RSP.
  - key_ack in the same cycle as the terminal count: ack wins; no timeout is counted.
- RSP: rsp_valid=1 and all rsp_* stable until rsp_ready=1; in that cycle go to IDLE.
  - rsp_valid drops and lookup_ready rises on the next cycle, so one lookup is outstanding at a time.
- Latency: lookup accepted at cycle 0, key_req=1 at cycle 1. An ack at cycle N gives rsp_valid=1 at cycle N+1.
- key_ack in IDLE or RSP: ignored (no data captured), cnt_spurious+1.
- Counters saturate at all-ones (no wrap).
- Reset mid-operation: key_req drops immediately on asynchronous assertion; an in-flight lookup is discarded with no response.
- rsp_key clears to zero in the cycle after the response handshake (key hygiene).

Optional Feature:
- Macro NTP_KEY_FETCH_CACHE_EN.
- Defined:
  - A one-entry cache holds {valid, id, key}, written on each successful fetch; timeouts do not write it.
  - A lookup whose ID matches a valid entry skips WAIT: rsp_valid=1 at cycle 1 with rsp_cached=1, key_req stays 0, cnt_fetch unchanged.
  - cache_flush=1 clears the valid bit. If cache_flush and a successful fetch write coincide, flush wins.
- Undefined: no cache storage; cache_flush is ignored; rsp_cached is tied to 0; every lookup goes to keymem.

Test Plan:
- Basic fetch: lookup_id=32'h0000_0007; keymem acks 3 cycles after key_req with key=256'hA5…A5 -> key_req high for exactly 3 cycles with key_id=7; rsp_valid with rsp_key=A5…A5, rsp_error=0; cnt_fetch=1.
- Timeout: TIMEOUT_CYCLES=16, no ack -> key_req high for 16 cycles, then rsp_error=1, rsp_key=0, cnt_timeout=1.
- Ack on terminal count: TIMEOUT_CYCLES=16, ack in the 16th WAIT cycle -> rsp_error=0, key delivered, cnt_timeout=0.
- Backpressure and spurious ack: hold rsp_ready=0 for 10 cycles and pulse key_ack during RSP -> rsp_* stable, lookup_ready=0, cnt_spurious=1.
- Reset in WAIT: deassert key_aresetn 2 cycles after key_req rises -> key_req=0 asynchronously, no rsp_valid after release, counters 0.
- Cache (macro defined): fetch ID 9, look up ID 9 again -> second response at cycle 1, rsp_cached=1, no key_req. Pulse cache_flush, look up ID 9 -> key_req asserted again.
